// File: rtl/count_seq_ctrl_pkg.sv
// count_seq_pkg: state encoding and shared limits for the counter sequencing controller.
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HIT   = 2'd3
  } state_t;

  // Below three cycles the compare cycle or a reload pulse could land on a count-enable.
  localparam int PRESCALE_MIN = 3;

endpackage

// File: rtl/count_seq_ctrl_tick_prescaler.sv
// tick_prescaler: free-running prescaler that emits a registered one-cycle tick
// in the cycle its count sits at PRESCALE-1. Holds its value while run is low.
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_nxt;

  assign pre_nxt = (pre_q == LAST) ? '0 : pre_q + 1'b1;

  // Advance/wrap the prescaler; tick is decoded from the value being loaded so it
  // lines up with the cycle the register holds PRESCALE-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      tick  <= 1'b0;
    end else if (clr) begin
      pre_q <= '0;
      tick  <= 1'b0;
    end else if (run) begin
      pre_q <= pre_nxt;
      tick  <= (pre_nxt == LAST);
    end else begin
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: drives en/rst/set of an external NBIT up counter, compares its Q
// against target and either halts or auto-reloads on a hit.
// Optional build macro LAP_CAPTURE_EN adds a lap capture register (lap/lap_q/lap_valid).
//
// state | meaning
// IDLE  | waiting for start; clear/preset act on the counter directly
// RUN   | prescaled counting, compare after each count-enable
// PAUSE | counting frozen, prescaler value held for resume
// HIT   | target reached with auto_reload off; start restarts from zero
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int NBIT     = 3,
  parameter int PRESCALE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            clear,
  input  logic            preset,
  input  logic            auto_reload,
  input  logic [NBIT-1:0] target,
  input  logic [NBIT-1:0] cnt_q,
`ifdef LAP_CAPTURE_EN
  input  logic            lap,
  output logic [NBIT-1:0] lap_q,
  output logic            lap_valid,
`endif
  output logic            cnt_en,
  output logic            cnt_rst,
  output logic            cnt_set,
  output logic            busy,
  output logic            done,
  output logic [1:0]      state
);

  if (PRESCALE < PRESCALE_MIN) begin : g_bad_prescale
    $error("count_seq_ctrl: PRESCALE must be at least %0d", PRESCALE_MIN);
  end

  state_t state_r;
  logic   check;
  logic   clr_pulse;

  // One command acts per cycle: clear > stop > start > preset.
  logic do_clear, do_stop, do_start, do_preset;
  assign do_clear  = clear;
  assign do_stop   = stop & ~clear;
  assign do_start  = start & ~stop & ~clear;
  assign do_preset = preset & ~start & ~stop & ~clear;

  // A compare pending from the last count-enable completes even if stop arrives,
  // but clear abandons it.
  logic hit;
  assign hit = check & (cnt_q == target) & ~do_clear;

  logic pre_clr, pre_run;
  assign pre_clr = do_clear | (do_start & ((state_r == IDLE) | (state_r == HIT)));
  assign pre_run = (state_r == RUN) & ~do_stop & ~do_clear;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (pre_run),
    .clr  (pre_clr),
    .tick (cnt_en)
  );

  // Counter reset must be visible for the whole async reset, not just after an edge.
  assign cnt_rst = rst | clr_pulse;
  assign busy    = (state_r == RUN);
  assign state   = state_r;

  // Sequencing FSM with registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      check     <= 1'b0;
      done      <= 1'b0;
      clr_pulse <= 1'b0;
      cnt_set   <= 1'b0;
    end else begin
      check     <= cnt_en & ~pre_clr;
      done      <= hit;
      clr_pulse <= do_clear | (hit & auto_reload) | ((state_r == HIT) & do_start);
      cnt_set   <= do_preset & ((state_r == IDLE) | (state_r == PAUSE));
      case (state_r)
        IDLE:  if (do_start) state_r <= RUN;
        RUN: begin
          if (do_clear)                state_r <= RUN;
          else if (do_stop)            state_r <= PAUSE;
          else if (hit & ~auto_reload) state_r <= HIT;
        end
        PAUSE: begin
          if (do_clear)      state_r <= IDLE;
          else if (do_start) state_r <= RUN;
        end
        HIT: begin
          if (do_clear)      state_r <= IDLE;
          else if (do_start) state_r <= RUN;
        end
      endcase
    end
  end

`ifdef LAP_CAPTURE_EN
  // Lap samples the same cnt_q the compare sees when both land in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q     <= '0;
      lap_valid <= 1'b0;
    end else begin
      lap_valid <= lap & (state_r == RUN);
      if (lap & (state_r == RUN)) lap_q <= cnt_q;
    end
  end
`endif

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed bench for count_seq_ctrl with a behavioural 3-bit counter.
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, clear, preset, auto_reload;
  logic [2:0] target;
  logic [2:0] cnt_q;
  logic       cnt_en, cnt_rst, cnt_set, busy, done;
  logic [1:0] state;
`ifdef LAP_CAPTURE_EN
  logic       lap = 1'b0;
  logic [2:0] lap_q;
  logic       lap_valid;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  count_seq_ctrl #(.NBIT(3), .PRESCALE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .preset      (preset),
    .auto_reload (auto_reload),
    .target      (target),
    .cnt_q       (cnt_q),
`ifdef LAP_CAPTURE_EN
    .lap         (lap),
    .lap_q       (lap_q),
    .lap_valid   (lap_valid),
`endif
    .cnt_en      (cnt_en),
    .cnt_rst     (cnt_rst),
    .cnt_set     (cnt_set),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  // External up counter being sequenced.
  always_ff @(posedge clk) begin
    if (cnt_rst)      cnt_q <= 3'd0;
    else if (cnt_set) cnt_q <= 3'd7;
    else if (cnt_en)  cnt_q <= cnt_q + 3'd1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    start = 1'b0; stop = 1'b0; clear = 1'b0; preset = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; stop = 1'b0; clear = 1'b0; preset = 1'b0;
    auto_reload = 1'b0; target = 3'd5;

    // Test 1: reset values
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_cnt_rst", int'(cnt_rst), 1);
      check_eq("rst_cnt_en", int'(cnt_en), 0);
      check_eq("rst_done", int'(done), 0);
      check_eq("rst_state", int'(state), 0);
      check_eq("rst_busy", int'(busy), 0);
    end
    rst = 1'b0;
    #1;
    check_eq("rel_cnt_rst", int'(cnt_rst), 0);

    // Test 2: target 5, halt on hit
    apply_reset();
    target = 3'd5; auto_reload = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      check_eq("t2_en", int'(cnt_en), (c % 4 == 0 && c >= 4 && c <= 20) ? 1 : 0);
      check_eq("t2_done", int'(done), (c == 22) ? 1 : 0);
      check_eq("t2_state", int'(state), (c == 0) ? 0 : (c < 22) ? 1 : 3);
      start = (c == 0);
      step();
    end

    // Test 3: target 2, auto-reload
    apply_reset();
    target = 3'd2; auto_reload = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      check_eq("t3_done", int'(done), (c >= 10 && (c - 10) % 8 == 0) ? 1 : 0);
      check_eq("t3_cnt_rst", int'(cnt_rst), (c >= 10 && (c - 10) % 8 == 0) ? 1 : 0);
      check_eq("t3_en", int'(cnt_en), (c >= 4 && c % 4 == 0) ? 1 : 0);
      check_eq("t3_state", int'(state), (c == 0) ? 0 : 1);
      start = (c == 0);
      step();
    end

    // Test 4: stop for 5 cycles with prescaler at 2, then resume
    apply_reset();
    target = 3'd7; auto_reload = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      check_eq("t4_state", int'(state), (c == 0) ? 0 : (c >= 4 && c <= 8) ? 2 : 1);
      check_eq("t4_busy", int'(busy), (c >= 1 && (c < 4 || c > 8)) ? 1 : 0);
      check_eq("t4_en", int'(cnt_en), (c == 10) ? 1 : 0);
      start = (c == 0 || c == 8);
      stop  = (c >= 3 && c <= 7);
      step();
    end
    start = 1'b0; stop = 1'b0;

    // Test 5: clear with start while running
    apply_reset();
    target = 3'd7; auto_reload = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      check_eq("t5_cnt_rst", int'(cnt_rst), (c == 3) ? 1 : 0);
      check_eq("t5_en", int'(cnt_en), (c == 6) ? 1 : 0);
      check_eq("t5_state", int'(state), (c == 0) ? 0 : 1);
      start = (c == 0 || c == 2);
      clear = (c == 2);
      step();
    end
    start = 1'b0; clear = 1'b0;

    // Test 6: preset, wrap to target 0, preset ignored in RUN
    apply_reset();
    target = 3'd0; auto_reload = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      check_eq("t6_set", int'(cnt_set), (c == 1) ? 1 : 0);
      check_eq("t6_en", int'(cnt_en), (c == 6) ? 1 : 0);
      check_eq("t6_done", int'(done), (c == 8) ? 1 : 0);
      check_eq("t6_state", int'(state), (c <= 2) ? 0 : (c <= 7) ? 1 : 3);
      if (c == 2) check_eq("t6_q_preset", int'(cnt_q), 7);
      if (c == 7) check_eq("t6_q_wrap", int'(cnt_q), 0);
      preset = (c == 0 || c == 4);
      start  = (c == 2);
      step();
    end
    preset = 1'b0; start = 1'b0;

    // Test 7: async reset in the middle of a cnt_en pulse
    apply_reset();
    target = 3'd7; auto_reload = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check_eq("t7_en_before", int'(cnt_en), 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t7_en_abort", int'(cnt_en), 0);
    check_eq("t7_cnt_rst", int'(cnt_rst), 1);
    check_eq("t7_state", int'(state), 0);
    check_eq("t7_busy", int'(busy), 0);
    step();
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
